hsv_core_issue_scoreboard: RTL
==============================

HSV_CORE_ISSUE_SCOREBOARD -- requirements
Module: hsv_core_issue_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning width of the opaque issue payload.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the hazard-stall performance counter.
REQ-003 SHALL have the following ports, one per line (name, direction, width, meaning):
- clk_core  in  1  core clock; all state updates on its rising edge.
- rst_core_n  in  1  reset; asynchronous assertion, active-low.
- flush_req  in  1  pipeline flush request.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  block can accept the upstream instruction.
- in_rs1  in  5  source register 1 address.
- in_rs2  in  5  source register 2 address.
- in_rd  in  5  destination register address.
- in_data  in  DATA_W  payload, passed through unchanged.
- out_valid  out  1  downstream instruction valid.
- out_ready  in  1  downstream accepts the instruction.
- out_rd  out  5  registered destination address.
- out_data  out  DATA_W  registered payload.
- commit_valid  in  1  a writeback retires a register.
- commit_rd  in  5  register address being retired.
- busy_mask  out  32  per-register pending-write bits.
- pending_count  out  6  population count of busy_mask.
- idle  out  1  high when busy_mask is zero and out_valid is low.
- stall_cycles  out  CNT_W  saturating count of hazard-stall cycles.

Function
REQ-004 SHALL raise hazard when busy[in_rs1], busy[in_rs2] or busy[in_rd] is set; address 0 never causes a hazard.
REQ-005 SHALL drive in_ready = !hazard && !flush_req && state==RUN && (!out_valid || out_ready).
REQ-006 SHALL accept an instruction when in_valid && in_ready, loading out_rd/out_data and setting out_valid on the next edge.
REQ-007 SHALL clear out_valid on the edge where out_valid && out_ready and no new acceptance occurs; it SHALL hold out_rd/out_data stable while out_valid && !out_ready.
REQ-008 SHALL set busy[in_rd] on the edge after acceptance when in_rd != 0; busy[0] SHALL always read 0.
REQ-009 SHALL clear busy[commit_rd] on the edge after commit_valid; a commit to a non-busy register or to register 0 SHALL be ignored.
REQ-010 SHALL let set win over clear when acceptance and commit target the same register in one cycle.
REQ-011 SHALL update pending_count combinationally from busy_mask (range 0..31).
REQ-012 SHALL increment stall_cycles on each cycle with in_valid && hazard && state==RUN, saturating at all-ones with no wrap.
REQ-013 SHALL implement FSM states RUN and FLUSH: RUN->FLUSH on flush_req; FLUSH->RUN after exactly one cycle when flush_req is low, otherwise remain in FLUSH.
REQ-014 SHALL, on the edge entering FLUSH, clear busy_mask and out_valid; commits and acceptances in that cycle SHALL be discarded; in_ready SHALL be 0 while in FLUSH.
REQ-015 SHALL leave stall_cycles unaffected by flush.

Reset
REQ-016 SHALL on rst_core_n low immediately force state=RUN, busy_mask=0, out_valid=0, out_rd=0, out_data=0, stall_cycles=0; pending_count=0 and idle=1 follow.
REQ-017 SHALL on reset mid-transaction drop any held output instruction without a handshake; the first acceptance is possible on the first edge after deassertion.

Configuration
REQ-018 SHALL support macro HSV_SCOREBOARD_COMMIT_BYPASS_EN: when defined, a same-cycle commit_valid to register r masks busy[r] out of the hazard term (REQ-004), so an instruction can be accepted in the commit cycle; when undefined, hazard uses registered busy_mask only and acceptance occurs at the earliest one cycle after the commit.

Verification
REQ-019 Reset: assert rst_core_n=0 mid-stream -> busy_mask=0, out_valid=0, idle=1, stall_cycles=0 without a clock edge.
REQ-020 RAW stall: accept rd=5, then present rs1=5 -> in_ready=0, stall_cycles increments each cycle; commit_rd=5 -> accepted next cycle (same cycle with bypass macro).
REQ-021 Backpressure: out_ready=0 with out_valid=1 -> out_data held, in_ready=0; out_ready=1 -> next instruction is loaded in the same edge as the drain.
REQ-022 Register 0: issue rd=0, then rs1=0, rs2=0 -> no busy bit, pending_count=0, no stall.
REQ-023 Flush: busy regs 3,7,9 and out_valid=1, pulse flush_req -> next cycle busy_mask=0, out_valid=0, in_ready=0 for one cycle, then RUN.
REQ-024 Set/clear collision: accept rd=4 while commit_rd=4 (bypass on) -> busy[4]=1 afterward; stall_cycles held at all-ones saturates with CNT_W=4 after 15 stalls.

Source files
------------

// File: rtl/hsv_core_issue_scoreboard.sv
// Issue-stage register scoreboard: tracks pending writes, stalls RAW/WAW hazards, one-deep output register.
// Optional HSV_SCOREBOARD_COMMIT_BYPASS_EN lets a same-cycle commit unblock the hazard check.
//
// state | meaning
// RUN   | normal issue, hazards checked against busy_mask
// FLUSH | one-cycle (or longer while flush_req held) drain; nothing accepted
module hsv_core_issue_scoreboard #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk_core,
  input  logic              rst_core_n,
  input  logic              flush_req,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_rd,
  output logic [DATA_W-1:0] out_data,
  input  logic              commit_valid,
  input  logic [4:0]        commit_rd,
  output logic [31:0]       busy_mask,
  output logic [5:0]        pending_count,
  output logic              idle,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t      state_q, state_d;
  logic [31:0] busy_q, busy_d, busy_haz;
  logic        hazard, accept;

  // busy_q[0] is never set, so address 0 can never produce a hazard.
  always_comb begin
    busy_haz = busy_q;
`ifdef HSV_SCOREBOARD_COMMIT_BYPASS_EN
    if (commit_valid) busy_haz[commit_rd] = 1'b0;
`endif
  end

  assign hazard = busy_haz[in_rs1] | busy_haz[in_rs2] | busy_haz[in_rd];
  assign accept = in_valid & in_ready;

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) state_q <= RUN;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (flush_req)  state_d = FLUSH;
      FLUSH:   if (!flush_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    in_ready = !hazard && !flush_req && (state_q == RUN) && (!out_valid || out_ready);
  end

  // Set is applied after clear so an acceptance wins a same-register collision.
  always_comb begin
    busy_d = busy_q;
    if (commit_valid) busy_d[commit_rd] = 1'b0;
    if (accept)       busy_d[in_rd]     = 1'b1;
    busy_d[0] = 1'b0;
    if (flush_req)    busy_d = '0;
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) busy_q <= '0;
    else             busy_q <= busy_d;
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      out_valid <= 1'b0;
      out_rd    <= '0;
      out_data  <= '0;
    end else if (flush_req) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_rd    <= in_rd;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      stall_cycles <= '0;
    end else if (in_valid && hazard && (state_q == RUN) && (stall_cycles != CNT_MAX)) begin
      stall_cycles <= stall_cycles + CNT_ONE;
    end
  end

  always_comb begin
    pending_count = '0;
    for (int i = 0; i < 32; i++) begin
      pending_count = pending_count + 6'(busy_q[i]);
    end
  end

  assign busy_mask = busy_q;
  assign idle      = (busy_q == '0) && !out_valid;

endmodule
